hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Sits beside the forwarding muxes in the D, E and M stages and drives their select codes.
- Keeps its own shadow pipeline of destination register, result-source type and Tnew for the E, M and W stages.
- Uses the D-stage Tuse values to decide between forwarding and stalling, and asserts a one-cycle stall/bubble when a value cannot be forwarded in time.

Parameters:
STALL_CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
rs_D  input  5  rs field of the instruction in D
rt_D  input  5  rt field of the instruction in D
tuse_rs_D  input  2  stages until rs is consumed: 0=D (compare/jr), 1=E (ALU), 2=M (store data), 3=unused
tuse_rt_D  input  2  same encoding, for rt
dst_D  input  5  GRF write address of the D instruction; 0 = no write
res_sel_D  input  2  result source: 00=ALU, 01=DM, 10=PC8, 11=none
stall  output  1  freeze PC and F/D register; D/E register loads a bubble
fwd_rs_D  output  3  D-stage rs compare select
fwd_rt_D  output  3  D-stage rt compare select
fwd_rs_E  output  3  E-stage ALU operand A select
fwd_rt_E  output  3  E-stage ALU operand B select
fwd_rt_M  output  2  M-stage store-data select
stall_cnt  output  STALL_CNT_W  number of stall cycles since reset, saturating

Behaviour:
- 3-bit select codes (D and E stages):
  - 000 = register value
  - 001 = ALUResult_M
  - 010 = PC8_M
  - 011 = W-stage write data
  - 1xx is never driven.
- fwd_rt_M codes: 01 = W-stage write data, 00 = register value.
- Shadow pipeline state, one register set per stage:
  - E stage: rs_E, rt_E, dst_E, res_E, tnew_E.
  - M stage: rt_M, dst_M, res_M, tnew_M.
  - W stage: dst_W.
- Tnew at entry to E:
  - ALU or PC8 -> 1.
  - DM -> 2.
  - none -> 0, and dst is forced to 0.
- Tnew on the move E->M: max(tnew_E-1, 0). Tnew is 0 in W by definition.
- Clock update, on each rising clk edge:
  - If stall=1: E loads a bubble (all fields 0).
  - If stall=0: E loads the D fields.
  - M always loads from E; W always loads from M.
- Reset (reset=0, asynchronous):
  - All shadow registers clear to 0 and stall_cnt clears to 0.
  - All outputs read 0 while reset is held.
  - Reset asserted mid-stall drops the pending hazard immediately; after release the pipeline is bubble-filled.
- Stall (combinational). For each source s in {rs, rt} with tuse_s_D != 3 and s_D != 0, stall if either:
  - s_D == dst_E and tuse_s_D < tnew_E, or
  - s_D == dst_M and tuse_s_D < tnew_M.
- D/E forwarding (combinational). For each source register r (rs_D, rt_D, rs_E, rt_E), in priority order:
  - r == 0 -> 000.
  - r == dst_M, tnew_M == 0, res_M == ALU -> 001.
  - r == dst_M, tnew_M == 0, res_M == PC8 -> 010.
  - r == dst_W -> 011.
  - Otherwise -> 000.
- E-stage result is never forwarded; any dependence on it is resolved by the stall logic.
- fwd_rt_M = 01 iff rt_M != 0 and rt_M == dst_W; otherwise 00.
- M/W result with res = DM: never forwarded from M. It forwards only from W, via code 011.
- Simultaneous match in M and W: M wins, because it holds the younger write.
- stall_cnt increments by 1 on each clock edge where stall=1. It holds at all-ones instead of wrapping.
- Stall is at most 2 consecutive cycles per D instruction (a DM producer in E with Tuse 0). The unit needs no external stall/flush input.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0, stall_cnt=0; after release with bubbles applied, still all 0.
- Load-use: lw $1 (dst=1, res=DM) then addu $2,$1,$3 (rs=1, tuse_rs=1) -> stall=1 for exactly 1 cycle, then fwd_rs_E=011 the next cycle, stall_cnt=1.
- Branch after ALU: addu $1 then beq $1,$0 (tuse_rs=0) -> stall 1 cycle, then fwd_rs_D=001; lw $1 then beq $1 -> stall 2 cycles, then fwd_rs_D=011.
- jal/jr: jal (dst=31, res=PC8) then jr $31 (tuse 0) -> 1 stall cycle, then fwd_rs_D=010.
- Store after load: lw $5 then sw $5,0($2) (rt=5, tuse_rt=2) -> no stall; fwd_rt_M=01 when sw is in M.
- $0 and priority: addu $0 followed by any use of $0 -> no stall, all selects 000. addu $4 (ALU), then addu $4 again, then use of $4 in E -> 001 (M wins over W). Assert reset during a 2-cycle stall -> stall drops to 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
// Tracks destination, result source and Tnew of the instructions in E, M and W.
// Compares them against the D-stage Tuse values to choose forwarding selects.
// Stalls (freezing F/D and bubbling E) when a value cannot arrive in time.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             rs_D,
  input  logic [4:0]             rt_D,
  input  logic [1:0]             tuse_rs_D,
  input  logic [1:0]             tuse_rt_D,
  input  logic [4:0]             dst_D,
  input  logic [1:0]             res_sel_D,
  output logic                   stall,
  output logic [2:0]             fwd_rs_D,
  output logic [2:0]             fwd_rt_D,
  output logic [2:0]             fwd_rs_E,
  output logic [2:0]             fwd_rt_E,
  output logic [1:0]             fwd_rt_M,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_DM   = 2'b01,
    RES_PC8  = 2'b10,
    RES_NONE = 2'b11
  } res_e;

  localparam logic [2:0] SEL_REG   = 3'b000;
  localparam logic [2:0] SEL_ALU_M = 3'b001;
  localparam logic [2:0] SEL_PC8_M = 3'b010;
  localparam logic [2:0] SEL_WD_W  = 3'b011;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Shadow pipeline
  logic [4:0] rs_E, rt_E, dst_E;
  res_e       res_E;
  logic [1:0] tnew_E;
  logic [4:0] rt_M, dst_M;
  res_e       res_M;
  logic [1:0] tnew_M;
  logic [4:0] dst_W;

  logic [4:0] dst_entry;
  logic [1:0] tnew_entry;
  logic [1:0] tnew_aged;
  logic       haz_rs, haz_rt;

  // A source stalls when a pending producer in E or M is not ready before use.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] de,  input logic [1:0] te,
                                      input logic [4:0] dm,  input logic [1:0] tm);
    return (tuse != 2'd3) && (src != 5'd0) &&
           (((src == de) && (tuse < te)) || ((src == dm) && (tuse < tm)));
  endfunction

  // Forwarding select: a ready ALU/PC8 result in M beats the older write in W.
  function automatic logic [2:0] fwd_sel(input logic [4:0] r,  input logic [4:0] dm,
                                         input logic [1:0] tm, input res_e rm,
                                         input logic [4:0] dw);
    if (r == 5'd0)                                   return SEL_REG;
    if ((r == dm) && (tm == 2'd0) && (rm == RES_ALU)) return SEL_ALU_M;
    if ((r == dm) && (tm == 2'd0) && (rm == RES_PC8)) return SEL_PC8_M;
    if (r == dw)                                     return SEL_WD_W;
    return SEL_REG;
  endfunction

  // Tnew and effective destination of the D instruction as it enters E
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    dst_entry  = dst_D;
    tnew_entry = 2'd0;
    case (res_e'(res_sel_D))
      RES_ALU, RES_PC8: tnew_entry = 2'd1;
      RES_DM:           tnew_entry = 2'd2;
      default:          dst_entry  = 5'd0;
    endcase
  end

  assign tnew_aged = (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;

  assign haz_rs = src_hazard(rs_D, tuse_rs_D, dst_E, tnew_E, dst_M, tnew_M);
  assign haz_rt = src_hazard(rt_D, tuse_rt_D, dst_E, tnew_E, dst_M, tnew_M);
  assign stall  = haz_rs | haz_rt;

  assign fwd_rs_D = fwd_sel(rs_D, dst_M, tnew_M, res_M, dst_W);
  assign fwd_rt_D = fwd_sel(rt_D, dst_M, tnew_M, res_M, dst_W);
  assign fwd_rs_E = fwd_sel(rs_E, dst_M, tnew_M, res_M, dst_W);
  assign fwd_rt_E = fwd_sel(rt_E, dst_M, tnew_M, res_M, dst_W);
  assign fwd_rt_M = ((rt_M != 5'd0) && (rt_M == dst_W)) ? 2'b01 : 2'b00;

  // Advance the shadow pipeline; E takes a bubble while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_E   <= 5'd0;
      rt_E   <= 5'd0;
      dst_E  <= 5'd0;
      res_E  <= RES_ALU;
      tnew_E <= 2'd0;
      rt_M   <= 5'd0;
      dst_M  <= 5'd0;
      res_M  <= RES_ALU;
      tnew_M <= 2'd0;
      dst_W  <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the old value of the stage before it.
      if (stall) begin
        rs_E   <= 5'd0;
        rt_E   <= 5'd0;
        dst_E  <= 5'd0;
        res_E  <= RES_ALU;
        tnew_E <= 2'd0;
      end else begin
        rs_E   <= rs_D;
        rt_E   <= rt_D;
        dst_E  <= dst_entry;
        res_E  <= res_e'(res_sel_D);
        tnew_E <= tnew_entry;
      end
      rt_M   <= rt_E;
      dst_M  <= dst_E;
      res_M  <= res_E;
      tnew_M <= tnew_aged;
      dst_W  <= dst_M;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes the reference model's
// expected outputs each cycle, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs_D, rt_D, dst_D;
  logic [1:0]    tuse_rs_D, tuse_rt_D, res_sel_D;
  logic          stall;
  logic [2:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [1:0]    fwd_rt_M;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .dst_D(dst_D), .res_sel_D(res_sel_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .stall_cnt(stall_cnt)
  );

  localparam logic [1:0] ALU = 2'b00, DM = 2'b01, PC8 = 2'b10, NONE = 2'b11;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] res;
  } inst_t;

  typedef struct packed {
    logic          stall;
    logic [2:0]    frs_d, frt_d, frs_e, frt_e;
    logic [1:0]    frt_m;
    logic [CW-1:0] cnt;
  } exp_t;

  // Reference model: instructions in flight, indexed by stage number (E=2, M=3, W=4)
  inst_t pipe [2:4];
  int    model_cnt;
  exp_t  exp_q [$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic inst_t mk(input logic [4:0] rs, rt, dst, input logic [1:0] res);
    inst_t i;
    i.rs = rs; i.rt = rt; i.dst = dst; i.res = res;
    return i;
  endfunction

  function automatic bit writes(input inst_t p);
    return (p.res != NONE) && (p.dst != 5'd0);
  endfunction

  // Cycles until the producer's value exists: ALU/PC8 results appear in M, loads in W.
  function automatic int tnew_at(input inst_t p, input int stage);
    int ready;
    if (!writes(p)) return 0;
    ready = (p.res == DM) ? 4 : 3;
    return (ready > stage) ? ready - stage : 0;
  endfunction

  function automatic bit hazard(input logic [4:0] src, input logic [1:0] tuse);
    if (tuse == 2'd3 || src == 5'd0) return 1'b0;
    for (int s = 2; s <= 3; s++)
      if (writes(pipe[s]) && pipe[s].dst == src && int'(tuse) < tnew_at(pipe[s], s))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] fwd(input logic [4:0] r);
    if (r == 5'd0) return 3'd0;
    if (writes(pipe[3]) && pipe[3].dst == r && tnew_at(pipe[3], 3) == 0) begin
      if (pipe[3].res == ALU) return 3'd1;
      if (pipe[3].res == PC8) return 3'd2;
    end
    if (writes(pipe[4]) && pipe[4].dst == r) return 3'd3;
    return 3'd0;
  endfunction

  function automatic exp_t model_out(input inst_t d, input logic [1:0] trs, trt);
    exp_t e;
    e.stall = hazard(d.rs, trs) || hazard(d.rt, trt);
    e.frs_d = fwd(d.rs);
    e.frt_d = fwd(d.rt);
    e.frs_e = fwd(pipe[2].rs);
    e.frt_e = fwd(pipe[2].rt);
    e.frt_m = (pipe[3].rt != 5'd0 && writes(pipe[4]) && pipe[4].dst == pipe[3].rt) ? 2'b01 : 2'b00;
    e.cnt   = CW'(model_cnt);
    return e;
  endfunction

  function automatic void advance(input bit st, input inst_t d);
    pipe[4] = pipe[3];
    pipe[3] = pipe[2];
    pipe[2] = st ? inst_t'(0) : d;
    if (st && model_cnt < CNT_MAX) model_cnt++;
  endfunction

  function automatic void clear_model();
    for (int s = 2; s <= 4; s++) pipe[s] = '0;
    model_cnt = 0;
  endfunction

  // One cycle: drive D, predict outputs, let the edge happen.
  task automatic issue(input inst_t d, input logic [1:0] trs, trt,
                       output logic st, output logic [2:0] frs_seen);
    exp_t e;
    rs_D = d.rs; rt_D = d.rt; dst_D = d.dst; res_sel_D = d.res;
    tuse_rs_D = trs; tuse_rt_D = trt;
    e = model_out(d, trs, trt);
    exp_q.push_back(e);
    st = e.stall;
    #1 frs_seen = fwd_rs_D;
    @(posedge clk);
    advance(e.stall, d);
    #1;
  endtask

  // Hold the instruction in D until the model says it is accepted.
  task automatic run(input inst_t d, input logic [1:0] trs, trt,
                     output int nst, output logic [2:0] frs_go);
    logic st;
    logic [2:0] f;
    nst = 0;
    frs_go = 3'd0;
    for (int k = 0; k < 4; k++) begin
      issue(d, trs, trt, st, f);
      if (!st) begin
        frs_go = f;
        return;
      end
      nst++;
    end
    check("stall_bound", nst, 2);
  endtask

  task automatic bubbles(input int n);
    int nst;
    logic [2:0] f;
    repeat (n) run(mk(0, 0, 0, NONE), 2'd3, 2'd3, nst, f);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    clear_model();
    repeat (n) begin
      rs_D = 5'($urandom); rt_D = 5'($urandom); dst_D = 5'($urandom);
      tuse_rs_D = 2'($urandom); tuse_rt_D = 2'($urandom); res_sel_D = 2'($urandom);
      exp_q.push_back(exp_t'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  // Monitor: the DUT presents outputs every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",     stall,     e.stall);
        check("fwd_rs_D",  fwd_rs_D,  e.frs_d);
        check("fwd_rt_D",  fwd_rt_D,  e.frt_d);
        check("fwd_rs_E",  fwd_rs_E,  e.frs_e);
        check("fwd_rt_E",  fwd_rt_E,  e.frt_e);
        check("fwd_rt_M",  fwd_rt_M,  e.frt_m);
        check("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    int nst;
    logic [2:0] f;
    exp_t e;
    inst_t d;
    clear_model();
    rs_D = '0; rt_D = '0; dst_D = '0; tuse_rs_D = '0; tuse_rt_D = '0; res_sel_D = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);
    bubbles(3);
    check("post_reset_cnt", stall_cnt, 0);

    // Load-use: one stall, then W-stage forwarding into E
    run(mk(0, 0, 1, DM), 2'd3, 2'd3, nst, f);
    run(mk(1, 3, 2, ALU), 2'd1, 2'd1, nst, f);
    check("loaduse_stalls", nst, 1);
    check("loaduse_fwd_rs_E", fwd_rs_E, 3);
    check("loaduse_cnt", stall_cnt, 1);

    // Branch after ALU and after load
    bubbles(3);
    run(mk(0, 0, 1, ALU), 2'd3, 2'd3, nst, f);
    run(mk(1, 0, 0, NONE), 2'd0, 2'd0, nst, f);
    check("br_alu_stalls", nst, 1);
    check("br_alu_fwd", f, 1);
    bubbles(3);
    run(mk(0, 0, 1, DM), 2'd3, 2'd3, nst, f);
    run(mk(1, 0, 0, NONE), 2'd0, 2'd0, nst, f);
    check("br_lw_stalls", nst, 2);
    check("br_lw_fwd", f, 3);

    // jal then jr $31
    bubbles(3);
    run(mk(0, 0, 31, PC8), 2'd3, 2'd3, nst, f);
    run(mk(31, 0, 0, NONE), 2'd0, 2'd3, nst, f);
    check("jr_stalls", nst, 1);
    check("jr_fwd", f, 2);

    // Store data after load: no stall, W->M forwarding
    bubbles(3);
    run(mk(0, 0, 5, DM), 2'd3, 2'd3, nst, f);
    run(mk(2, 5, 0, NONE), 2'd1, 2'd2, nst, f);
    check("sw_stalls", nst, 0);
    bubbles(1);
    check("sw_fwd_rt_M", fwd_rt_M, 1);

    // Writes to $0 never create hazards or forwards
    bubbles(3);
    run(mk(1, 2, 0, ALU), 2'd1, 2'd1, nst, f);
    run(mk(0, 0, 6, ALU), 2'd0, 2'd0, nst, f);
    check("zero_stalls", nst, 0);
    check("zero_fwd_rs_E", fwd_rs_E, 0);

    // Double write of $4: the younger one in M wins
    bubbles(3);
    run(mk(0, 0, 4, ALU), 2'd3, 2'd3, nst, f);
    run(mk(0, 0, 4, ALU), 2'd3, 2'd3, nst, f);
    run(mk(4, 0, 7, ALU), 2'd1, 2'd1, nst, f);
    check("mwins_stalls", nst, 0);
    check("mwins_fwd_rs_E", fwd_rs_E, 1);

    // Reset asserted mid-stall drops the stall immediately
    bubbles(3);
    run(mk(0, 0, 7, DM), 2'd3, 2'd3, nst, f);
    d = mk(7, 0, 0, NONE);
    rs_D = d.rs; rt_D = d.rt; dst_D = d.dst; res_sel_D = d.res;
    tuse_rs_D = 2'd0; tuse_rt_D = 2'd3;
    e = model_out(d, 2'd0, 2'd3);
    exp_q.push_back(e);
    #1 check("midstall_pre", stall, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    clear_model();
    #1;
    check("midstall_drop", stall, 0);
    check("midstall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    do_reset(2);
    bubbles(3);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      d = mk(rnd_reg(), rnd_reg(), rnd_reg(), 2'($urandom));
      run(d, 2'($urandom), 2'($urandom), nst, f);
    end

    // Drive the counter into saturation
    for (int n = 0; n < 40; n++) begin
      run(mk(0, 0, 1, DM), 2'd3, 2'd3, nst, f);
      run(mk(1, 0, 0, NONE), 2'd0, 2'd3, nst, f);
    end
    check("cnt_saturated", stall_cnt, CNT_MAX);

    @(negedge clk);
    #1 check("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
